// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : simon_pkg
//  Description : Shared definitions for the SIMON round sequencing controller:
//                controller state encoding, the five 62-bit key-schedule
//                z constants, and the (N,M) -> z_j selection function.
//                z constants are written with character 0 of the published
//                string as the MSB (bit 61), so bit i of the sequence is
//                c_Zj[61 - i].
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    localparam logic [61:0] c_Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] c_Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] c_Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] c_Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] c_Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    // Returns j for a legal (word size, key words) pair, -1 otherwise.
    function automatic int zsel(input int n, input int m);
        int j;
        j = -1;
        case (n)
            16: if (m == 4) j = 0;
            24: if (m == 3) j = 0; else if (m == 4) j = 1;
            32: if (m == 3) j = 2; else if (m == 4) j = 3;
            48: if (m == 2) j = 2; else if (m == 3) j = 3;
            64: if (m == 2) j = 2; else if (m == 3) j = 3; else if (m == 4) j = 4;
            default: j = -1;
        endcase
        return j;
    endfunction

    function automatic logic [61:0] z_const(input int j);
        logic [61:0] z;
        case (j)
            0:       z = c_Z0;
            1:       z = c_Z1;
            2:       z = c_Z2;
            3:       z = c_Z3;
            4:       z = c_Z4;
            default: z = '0;
        endcase
        return z;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : simon_round_ctrl_if
//  Description : Handshake and datapath-control bundle of the SIMON round
//                controller.
//                master : controller side (drives acks, enables, status)
//                slave  : surrounding blocks (input/output staging, datapath)
//  Signals     : newData, newKey, readData          (slave -> master)
//                ackData, ackKey, loadBlock, loadKey, roundEN, keyEN,
//                roundCOUNT[Cb], zBit, lastRound, doneData, busy
//                                                    (master -> slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface simon_round_ctrl_if #(
    parameter int Cb = 5
);
    logic          newData;
    logic          newKey;
    logic          readData;
    logic          ackData;
    logic          ackKey;
    logic          loadBlock;
    logic          loadKey;
    logic          roundEN;
    logic          keyEN;
    logic [Cb-1:0] roundCOUNT;
    logic          zBit;
    logic          lastRound;
    logic          doneData;
    logic          busy;

    modport master (
        input  newData, newKey, readData,
        output ackData, ackKey, loadBlock, loadKey, roundEN, keyEN,
               roundCOUNT, zBit, lastRound, doneData, busy
    );

    modport slave (
        output newData, newKey, readData,
        input  ackData, ackKey, loadBlock, loadKey, roundEN, keyEN,
               roundCOUNT, zBit, lastRound, doneData, busy
    );
endinterface
`default_nettype wire

// File: rtl/simon_zseq.sv
`default_nettype none
// ============================================================================
//  Module      : simon_zseq
//  Description : Key-schedule z-constant bit generator. A mod-62 index
//                counter is cleared during LOAD and steps on every key
//                expansion step once the round index has reached M; the
//                selected z_j bit at that index is presented while the key
//                schedule is advancing, 0 otherwise. Only instantiated when
//                SIMON_ZSEQ_EN is defined.
//  Ports       : clk, R (sync active-high reset)
//                i_load         - controller is in LOAD
//                i_key_en       - key schedule advances this cycle
//                i_round_count  - current round index
//                o_zbit         - z bit for the current step
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_zseq
    import simon_pkg::*;
#(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int Cb = 5
) (
    input  wire logic          clk,
    input  wire logic          R,
    input  wire logic          i_load,
    input  wire logic          i_key_en,
    input  wire logic [Cb-1:0] i_round_count,
    output logic               o_zbit
);

    localparam logic [61:0] c_Z = z_const(zsel(N, M));

    logic [5:0] r_idx;
    logic       w_past_m;
    logic [5:0] w_pos;

    // First M rounds use the initial key words directly; no z bit consumed.
    assign w_past_m = (32'(i_round_count) >= M);
    assign w_pos    = 6'd61 - r_idx;
    assign o_zbit   = i_key_en & w_past_m & c_Z[w_pos];

    always_ff @(posedge clk) begin
        if (R) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= '0;
        end else if (i_key_en && w_past_m) begin
            r_idx <= (r_idx == 6'd61) ? 6'd0 : r_idx + 6'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/simon_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : simon_round_ctrl
//  Description : Sequencing controller for the SIMON encryption core.
//                WAIT   - waits for plaintext and key; acks both on accept
//                LOAD   - one cycle, datapath loads block and key
//                COMPUTE- T cycles of round/key-schedule enables
//                WRITE  - result held (doneData) until readData
//                Optional feature macro SIMON_ZSEQ_EN: when defined, zBit is
//                generated internally by simon_zseq; otherwise zBit is 0.
//  Ports       : clk   - clock, rising edge
//                R     - synchronous active-high reset
//                bus   - simon_round_ctrl_if.master (handshakes, enables,
//                        roundCOUNT, zBit, lastRound, doneData, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int T  = 32,
    parameter int Cb = 5
) (
    input wire logic           clk,
    input wire logic           R,
    simon_round_ctrl_if.master bus
);

    localparam int            c_ZJ   = zsel(N, M);
    localparam logic [Cb-1:0] c_LAST = Cb'(T - 1);

    if (c_ZJ < 0) begin : g_bad_nm
        $error("simon_round_ctrl: unsupported (N,M) pair");
    end
    if (T < 1 || (2 ** Cb) < T) begin : g_bad_cb
        $error("simon_round_ctrl: Cb too narrow for T rounds");
    end

    state_t        r_state;
    logic [Cb-1:0] r_cnt;
    logic          r_load;
    logic          r_round_en;
    logic          r_last;
    logic          r_done;
    logic          r_busy;
    logic          w_take;
    logic          w_zbit;

    // Only the ack is combinational; R gates it so reset never acks.
    assign w_take = (r_state == S_WAIT) & bus.newData & bus.newKey & ~R;

    always_ff @(posedge clk) begin
        if (R) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            r_load     <= 1'b0;
            r_round_en <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_take) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_COMPUTE;
                    r_cnt      <= '0;
                    r_round_en <= 1'b1;
                    r_last     <= (c_LAST == '0);
                end
                S_COMPUTE: begin
                    if (r_cnt == c_LAST) begin
                        // Counter holds at T-1 through WRITE.
                        r_state    <= S_WRITE;
                        r_round_en <= 1'b0;
                        r_last     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_last <= ((r_cnt + 1'b1) == c_LAST);
                    end
                end
                S_WRITE: begin
                    if (bus.readData) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

`ifdef SIMON_ZSEQ_EN
    simon_zseq #(
        .N  (N),
        .M  (M),
        .Cb (Cb)
    ) u_zseq (
        .clk           (clk),
        .R             (R),
        .i_load        (r_load),
        .i_key_en      (r_round_en),
        .i_round_count (r_cnt),
        .o_zbit        (w_zbit)
    );
`else
    // Datapath supplies its own z constant in this build.
    assign w_zbit = 1'b0;
`endif

    assign bus.ackData    = w_take;
    assign bus.ackKey     = w_take;
    assign bus.loadBlock  = r_load;
    assign bus.loadKey    = r_load;
    assign bus.roundEN    = r_round_en;
    assign bus.keyEN      = r_round_en;
    assign bus.roundCOUNT = r_cnt;
    assign bus.zBit       = w_zbit;
    assign bus.lastRound  = r_last;
    assign bus.doneData   = r_done;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
